// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU: opcodes, FSM encoding
// and the long-operation classifier.
package alu_pkg;

   localparam int OP_W_DEFAULT = 5;

   localparam logic [OP_W_DEFAULT-1:0] ALUOp_nop   = 5'b00000;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_lui   = 5'b00001;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_auipc = 5'b00010;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_add   = 5'b00011;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_sub   = 5'b00100;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_and   = 5'b00101;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_or    = 5'b00110;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_xor   = 5'b00111;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_sll   = 5'b01000;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_srl   = 5'b01001;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_sra   = 5'b01010;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_slt   = 5'b01011;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_sltu  = 5'b01100;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_mul   = 5'b01101;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_div   = 5'b01110;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_divu  = 5'b01111;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_rem   = 5'b10000;
   localparam logic [OP_W_DEFAULT-1:0] ALUOp_remu  = 5'b10001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   function automatic logic is_long_op(input logic [OP_W_DEFAULT-1:0] op);
      return (op == ALUOp_mul) || (op == ALUOp_div) || (op == ALUOp_divu) ||
             (op == ALUOp_rem) || (op == ALUOp_remu);
   endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring divider: WIDTH iterations on magnitudes, then one sign fix-up
// cycle during which done is high and result is valid.
module alu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             want_rem,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   logic run_q, run_d, fix_q, fix_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, a_q, a_d;
   logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, div0_q, div0_d, ovf_q, ovf_d;
   logic sel_rem_q, sel_rem_d;

   logic a_neg, b_neg;
   logic [WIDTH:0] rem_sh, diff;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign a_neg  = is_signed && a[WIDTH-1];
   assign b_neg  = is_signed && b[WIDTH-1];
   assign rem_sh = {rem_q, quot_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   always_comb begin
      run_d     = run_q;
      fix_d     = 1'b0;
      cnt_d     = cnt_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      a_d       = a_q;
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      sel_rem_d = sel_rem_q;
      if (start) begin
         run_d     = 1'b1;
         cnt_d     = '0;
         quot_d    = a_neg ? (-a) : a;
         dvs_d     = b_neg ? (-b) : b;
         rem_d     = '0;
         a_d       = a;
         neg_q_d   = a_neg ^ b_neg;
         neg_r_d   = a_neg;
         div0_d    = (b == '0);
         ovf_d     = is_signed && (a == MIN_INT) && (b == '1);
         sel_rem_d = want_rem;
      end else if (run_q) begin
         // Keep the trial difference only when it did not borrow.
         quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
         rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == LAST_ITER) begin
            run_d = 1'b0;
            fix_d = 1'b1;
         end
      end
   end

   always_comb begin
      q_fix = neg_q_q ? (-quot_q) : quot_q;
      r_fix = neg_r_q ? (-rem_q) : rem_q;
      if (div0_q) begin
         q_fix = '1;
         r_fix = a_q;
      end else if (ovf_q) begin
         q_fix = a_q;
         r_fix = '0;
      end
      result = sel_rem_q ? r_fix : q_fix;
   end

   assign done = fix_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         fix_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         fix_q <= fix_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      sel_rem_q <= sel_rem_d;
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides: single-cycle ops,
// shift-add multiply and restoring divide/remainder.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = OP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             Zero,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   state_e state_q, state_d;
   logic [SHW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic zero_q, zero_d, out_valid_q, out_valid_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;

   logic accept, long_op, div_start, div_signed, div_rem, div_done;
   logic [WIDTH-1:0] div_result, alu_res, acc_step;
   logic [SHW-1:0] shamt;
   logic signed [WIDTH-1:0] a_s, b_s;

   assign a_s        = A;
   assign b_s        = B;
   assign shamt      = B[SHW-1:0];
   assign long_op    = is_long_op(ALUOp);
   assign accept     = in_valid && in_ready;
   assign div_start  = accept && long_op && (ALUOp != ALUOp_mul);
   assign div_signed = (ALUOp == ALUOp_div) || (ALUOp == ALUOp_rem);
   assign div_rem    = (ALUOp == ALUOp_rem) || (ALUOp == ALUOp_remu);
   assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);

   alu_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .is_signed (div_signed),
      .want_rem  (div_rem),
      .a         (A),
      .b         (B),
      .done      (div_done),
      .result    (div_result)
   );

   always_comb begin
      alu_res = '0;
      case (ALUOp)
         ALUOp_lui, ALUOp_auipc, ALUOp_add: alu_res = A + B;
         ALUOp_sub:  alu_res = A - B;
         ALUOp_and:  alu_res = A & B;
         ALUOp_or:   alu_res = A | B;
         ALUOp_xor:  alu_res = A ^ B;
         ALUOp_sll:  alu_res = A << shamt;
         ALUOp_srl:  alu_res = A >> shamt;
         ALUOp_sra:  alu_res = a_s >>> shamt;
         ALUOp_slt:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         ALUOp_sltu: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         default:    alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && long_op) state_d = (ALUOp == ALUOp_mul) ? MUL : DIV;
         MUL:  if (cnt_q == LAST_ITER) state_d = IDLE;
         DIV:  if (div_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
      busy     = (state_q == MUL) || (state_q == DIV);
   end

   always_comb begin
      cnt_d       = cnt_q;
      c_d         = c_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q && !out_ready;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      case (state_q)
         IDLE: if (accept) begin
            if (long_op) begin
               cnt_d    = '0;
               mcand_d  = A;
               mplier_d = B;
               acc_d    = '0;
            end else begin
               // nop completes the handshake but leaves C/Zero untouched.
               out_valid_d = 1'b1;
               if (ALUOp != ALUOp_nop) begin
                  c_d    = alu_res;
                  zero_d = (alu_res == '0);
               end
            end
         end
         MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               cnt_d       = '0;
               c_d         = acc_step;
               zero_d      = (acc_step == '0);
               out_valid_d = 1'b1;
            end
         end
         DIV: if (div_done) begin
            c_d         = div_result;
            zero_d      = (div_result == '0);
            out_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         c_q         <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         c_q         <= c_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

   assign C         = c_q;
   assign Zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute ALU in the RISC-V lab core.
- Adds full RV32IM-style integer ops: logic, shifts, compares, iterative multiply, and restoring divide/remainder.
- Uses a valid/ready handshake on both sides so the pipeline can stall on long ops.
- Sits in the EX stage between operand muxes and the EX/MEM register.

Parameters:
- WIDTH, 32: operand/result width in bits (≥ 8, power of two).
- OP_W, 5: ALUOp width.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridable).

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: A/B/ALUOp valid.
- in_ready, out, 1: block accepts an operation this cycle.
- A, in, WIDTH: operand A (signed view where op requires).
- B, in, WIDTH: operand B.
- ALUOp, in, OP_W: operation code.
- out_valid, out, 1: C/Zero valid.
- out_ready, in, 1: consumer takes the result this cycle.
- C, out, WIDTH: result.
- Zero, out, 1: C == 0.
- busy, out, 1: state is MUL or DIV.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, out_valid=0, C=0, Zero=1, busy=0, iteration counter=0. Asserting rst mid-MUL/DIV aborts the op and discards the result.
- Opcodes: 00000 nop, 00001 lui, 00010 auipc, 00011 add, 00100 sub, 00101 and, 00110 or, 00111 xor, 01000 sll, 01001 srl, 01010 sra, 01011 slt, 01100 sltu, 01101 mul, 01110 div, 01111 divu, 10000 rem, 10001 remu. Any other code gives C=0.
- lui/auipc/add all compute A+B, modulo 2^WIDTH with no overflow flag.
- nop: C holds its previous value; out_valid still pulses so the handshake completes.
- Shifts use B[SHW-1:0] only. sra is arithmetic on A.
- slt: signed compare; sltu: unsigned compare. Result is 1 or 0, zero-extended.
- Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Output rule: while out_valid && !out_ready, C/Zero/out_valid hold stable. out_valid drops the cycle after the consumer accepts unless a new result is produced in that same edge.
- FSM states: IDLE, MUL, DIV.
  - IDLE + accepted single-cycle op: C registered at the next edge, out_valid=1. Latency 1; throughput 1 per cycle when out_ready is held high.
  - IDLE + accepted mul: go to MUL, counter=0.
  - IDLE + accepted div/divu/rem/remu: go to DIV, counter=0.
  - Before entering DIV, latch operands as magnitudes plus sign flags (signed ops only).
- MUL: shift-add, one bit of B per cycle, WIDTH cycles. C = low WIDTH bits of A*B (identical for signed/unsigned). On counter==WIDTH-1: load C, out_valid=1, return to IDLE. Latency WIDTH+1 from acceptance.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then a one-cycle sign fix-up. Latency WIDTH+2.
  - Quotient sign = sA^sB; remainder takes the sign of the dividend.
  - Divide by zero (B==0, both latency paths unchanged): quotient = all ones, remainder = A.
  - Signed overflow (A = min_int, B = -1, div/rem): quotient = A, remainder = 0.
  - Special cases are detected at acceptance but still take the full latency, so timing is data-independent.
- Zero is registered together with C and always equals (C==0).
- in_valid while busy is ignored because in_ready=0; the producer must hold its request.

Decomposition:
- Package alu_pkg:
  - ALUOp localparams (ALUOp_nop … ALUOp_remu, values above).
  - FSM state encoding (IDLE=2'd0, MUL=2'd1, DIV=2'd2).
  - OP_W default.
  - Helper function is_long_op(op).
- One natural sub-module, alu_divider: restoring divider with start/done, signed/unsigned and quotient/remainder select, parametrised by WIDTH. The multiplier stays inline; it is simple enough.

Test Plan:
- Reset then add A=5, B=-7, out_ready=1 → next cycle C=32'hFFFFFFFE, Zero=0, out_valid=1; sub A=3, B=3 → C=0, Zero=1.
- sra A=32'h80000000, B=32'h00000024 (shamt=4) → C=32'hF8000000; srl same → 32'h08000000; sltu A=1, B=-1 → 1; slt same → 0.
- mul A=32'h0001_0003, B=32'h0000_0005 → busy for 32 cycles, in_ready=0 throughout, C=32'h0005_000F at cycle 33, out_valid for one cycle.
- div A=-7, B=2 → C=-3; rem → C=-1; divu A=7, B=0 → C=32'hFFFFFFFF; rem A=32'h80000000, B=-1 → C=0; div same → C=32'h80000000; each at latency 34.
- Backpressure: out_ready=0 for 5 cycles after an add → C/out_valid stable, in_ready=0; raise out_ready → in_ready=1 the same cycle, and the back-to-back add is accepted.
- rst=1 at cycle 10 of a div → next cycle state=IDLE, out_valid=0, C=0, in_ready=1; the following add completes normally.
